// File: rtl/mii_tx_sched_pkg.sv
// Shared types and helpers for the MII/RMII TX frame scheduler.
//   sched_state_t : scheduler FSM state (IDLE, SEND0, SEND1, GAP)
//   port_idx_t    : one-bit source port index
//   PORT_FRAMED   : port 0, framed stream (preamble + payload + FCS)
//   PORT_BYPASS   : port 1, raw bypass stream
//   cnt_width()   : bit width able to hold 0..max_val (never less than 1)
package mii_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  typedef logic port_idx_t;

  localparam port_idx_t PORT_FRAMED = 1'b0;
  localparam port_idx_t PORT_BYPASS = 1'b1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mii_tx_gap_timer.sv
// Loadable down-counter that times the inter-frame gap.
// Ports:
//   clock, aresetn : clock and asynchronous active-low reset
//   load           : load 'value' into the counter this cycle
//   value          : gap length in cycles
//   done           : high in the last gap cycle (count at 1 or already 0)
module mii_tx_gap_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             aresetn,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with N, the count is N in the first gap cycle and 1 in the Nth,
  // so the owner leaves the gap after exactly N cycles.
  assign done = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/mii_tx_frame_scheduler.sv
// Frame-atomic arbiter for the MII/RMII TX path. Port 0 (framed) and port 1
// (bypass) compete for the serializer; a granted frame passes through
// combinationally until its tlast handshake, then IFG_CYCLES idle cycles follow.
// Optional frame counters are built when MII_TX_SCHED_STATS_EN is defined.
// Ports:
//   clock, aresetn            : clock and asynchronous active-low reset
//   saxis_0_*                 : framed stream in (tdata/tvalid/tuser/tlast, tready out)
//   saxis_1_*                 : bypass stream in (same signals)
//   maxis_*                   : stream to serializer (tready in)
//   cfg_rr                    : 1 round-robin, 0 port-0 priority with burst limit
//   busy                      : high whenever the FSM is not IDLE
//   stat_clear                : synchronous counter clear (stats build only)
//   stat_frames_0/1           : completed frames per port (0 without stats)
//   dbg_state                 : current FSM state encoding
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high; tvalid never depends on tready, and the granted port sees
// maxis_tready directly while the other port's tready is held at 0.
module mii_tx_frame_scheduler
  import mii_tx_sched_pkg::*;
#(
  parameter int IFG_CYCLES = 24,
  parameter int MAX_BURST  = 4,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  aresetn,
  input  logic [7:0]            saxis_0_tdata,
  input  logic                  saxis_0_tvalid,
  output logic                  saxis_0_tready,
  input  logic                  saxis_0_tuser,
  input  logic                  saxis_0_tlast,
  input  logic [7:0]            saxis_1_tdata,
  input  logic                  saxis_1_tvalid,
  output logic                  saxis_1_tready,
  input  logic                  saxis_1_tuser,
  input  logic                  saxis_1_tlast,
  output logic [7:0]            maxis_tdata,
  output logic                  maxis_tvalid,
  input  logic                  maxis_tready,
  output logic                  maxis_tuser,
  output logic                  maxis_tlast,
  input  logic                  cfg_rr,
  output logic                  busy,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] stat_frames_0,
  output logic [STAT_WIDTH-1:0] stat_frames_1,
  output logic [1:0]            dbg_state
);

  localparam int GAP_W   = cnt_width(IFG_CYCLES);
  localparam int BURST_W = cnt_width(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

  sched_state_t       state_q, state_d;
  port_idx_t          last_grant_q, last_grant_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  port_idx_t          pick;
  logic               gap_load;
  logic               gap_done;
  logic               eof_hs;

  // State register
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_BYPASS;
      burst_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
    end
  end

  // Next-state and arbitration
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_d      = burst_q;
    gap_load     = 1'b0;
    pick         = PORT_FRAMED;
    case (state_q)
      IDLE: begin
        if (saxis_0_tvalid && saxis_1_tvalid) begin
          if (cfg_rr) begin
            pick = ~last_grant_q;
          end else if (burst_q == BURST_LIMIT) begin
            pick = PORT_BYPASS;
          end else begin
            pick = PORT_FRAMED;
          end
        end else if (saxis_1_tvalid) begin
          pick = PORT_BYPASS;
        end

        if (saxis_0_tvalid || saxis_1_tvalid) begin
          last_grant_d = pick;
          // Burst count only grows while port 1 is kept waiting by port 0.
          if (pick == PORT_BYPASS || !saxis_1_tvalid) begin
            burst_d = '0;
          end else if (burst_q != BURST_LIMIT) begin
            burst_d = burst_q + BURST_W'(1);
          end
          state_d = (pick == PORT_BYPASS) ? SEND1 : SEND0;
        end
      end
      SEND0, SEND1: begin
        if (eof_hs) begin
          if (IFG_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = GAP;
            gap_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pure pass-through of the granted port, zeros otherwise
  always_comb begin
    maxis_tdata    = '0;
    maxis_tvalid   = 1'b0;
    maxis_tuser    = 1'b0;
    maxis_tlast    = 1'b0;
    saxis_0_tready = 1'b0;
    saxis_1_tready = 1'b0;
    case (state_q)
      SEND0: begin
        maxis_tdata    = saxis_0_tdata;
        maxis_tvalid   = saxis_0_tvalid;
        maxis_tuser    = saxis_0_tuser;
        maxis_tlast    = saxis_0_tlast;
        saxis_0_tready = maxis_tready;
      end
      SEND1: begin
        maxis_tdata    = saxis_1_tdata;
        maxis_tvalid   = saxis_1_tvalid;
        maxis_tuser    = saxis_1_tuser;
        maxis_tlast    = saxis_1_tlast;
        saxis_1_tready = maxis_tready;
      end
      default: ;
    endcase
  end

  assign eof_hs    = maxis_tvalid & maxis_tready & maxis_tlast;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  mii_tx_gap_timer #(
    .CNT_W (GAP_W)
  ) u_gap_timer (
    .clock   (clock),
    .aresetn (aresetn),
    .load    (gap_load),
    .value   (GAP_W'(IFG_CYCLES)),
    .done    (gap_done)
  );

`ifdef MII_TX_SCHED_STATS_EN
  logic [STAT_WIDTH-1:0] frames0_q, frames1_q;

  // Clear wins over a same-cycle frame completion.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      frames0_q <= '0;
      frames1_q <= '0;
    end else if (stat_clear) begin
      frames0_q <= '0;
      frames1_q <= '0;
    end else begin
      if (eof_hs && state_q == SEND0) frames0_q <= frames0_q + STAT_WIDTH'(1);
      if (eof_hs && state_q == SEND1) frames1_q <= frames1_q + STAT_WIDTH'(1);
    end
  end

  assign stat_frames_0 = frames0_q;
  assign stat_frames_1 = frames1_q;
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign stat_frames_0     = '0;
  assign stat_frames_1     = '0;
`endif

endmodule
